// File: rtl/softmax_result_uart_tx.sv
// Captures a softmax probability vector, finds the winning class by sequential argmax,
// drives one-hot LEDs and sends a framed result (header, class, probabilities, XOR checksum) over UART 8N1.
module softmax_result_uart_tx #(
    parameter int         DATA_WIDTH   = 16,
    parameter int         NUM_CLASSES  = 4,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*NUM_CLASSES-1:0] in_vec,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [2:0]                        class_idx,
    output logic [7:0]                        led,
    output logic                              frame_done,
    output logic                              overrun
);

    localparam int NB = 3 + 2 * NUM_CLASSES;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(CLKS_PER_BIT - 2);
    localparam logic [4:0]    LAST_BYTE  = 5'(NB - 1);
    localparam logic [2:0]    LAST_CLASS = 3'(NUM_CLASSES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]                        state;
    logic                              in_valid_q;
    logic                              trig;
    logic [DATA_WIDTH*NUM_CLASSES-1:0] vec_q;
    logic [2:0]                        scan_cnt;
    logic [DATA_WIDTH-1:0]             best_val;
    logic [2:0]                        best_idx;
    logic [DATA_WIDTH-1:0]             cand;
    logic                              take_new;
    logic [2:0]                        win_idx;
    logic [4:0]                        byte_idx;
    logic [4:0]                        word_sel;
    logic [15:0]                       word16;
    logic [7:0]                        cur_byte;
    logic [7:0]                        csum;
    logic [7:0]                        sh;
    logic [2:0]                        bit_cnt;
    logic [CW-1:0]                     clk_cnt;
    logic                              tx_next;

    assign trig     = in_valid & ~in_valid_q;
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        cand     = vec_q[scan_cnt*DATA_WIDTH +: DATA_WIDTH];
        take_new = (scan_cnt == 3'd0) || (cand > best_val);
        win_idx  = take_new ? scan_cnt : best_idx;
    end

    always_comb begin
        word_sel = (byte_idx - 5'd2) >> 1;
        word16   = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < DATA_WIDTH) word16[b] = vec_q[int'(word_sel)*DATA_WIDTH + b];
        end
        if (byte_idx == 5'd0)           cur_byte = HEADER;
        else if (byte_idx == 5'd1)      cur_byte = {5'd0, class_idx};
        else if (byte_idx == LAST_BYTE) cur_byte = csum;
        else if (!byte_idx[0])          cur_byte = word16[15:8];
        else                            cur_byte = word16[7:0];
    end

    always_comb begin
        case (state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = sh[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            in_valid_q <= 1'b0;
            vec_q      <= '0;
            scan_cnt   <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            clk_cnt    <= '0;
            tx         <= 1'b1;
            class_idx  <= '0;
            led        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
            tx         <= tx_next;
            frame_done <= (state == S_DONE);
            if (trig && state != S_IDLE) overrun <= 1'b1;

            case (state)
                S_IDLE: if (trig) begin
                    vec_q    <= in_vec;
                    scan_cnt <= '0;
                    state    <= S_SCAN;
                end
                S_SCAN: begin
                    best_val <= take_new ? cand : best_val;
                    best_idx <= win_idx;
                    scan_cnt <= scan_cnt + 3'd1;
                    if (scan_cnt == LAST_CLASS) begin
                        class_idx <= win_idx;
                        led       <= 8'd1 << win_idx;
                        byte_idx  <= '0;
                        csum      <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sh      <= cur_byte;
                    clk_cnt <= '0;
                    if (byte_idx != 5'd0 && byte_idx != LAST_BYTE) csum <= csum ^ cur_byte;
                    state   <= S_START;
                end
                S_START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        sh      <= sh >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                // The LOAD cycle supplies the final stop-bit cycle so bytes run back-to-back.
                S_STOP: begin
                    if (byte_idx == LAST_BYTE && clk_cnt == BIT_LAST) begin
                        state <= S_DONE;
                    end else if (byte_idx != LAST_BYTE && clk_cnt == STOP_LAST) begin
                        byte_idx <= byte_idx + 5'd1;
                        state    <= S_LOAD;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_result_uart_tx.sv
// Randomized bench: reference argmax/frame model, per-cycle tx capture and decode of every UART frame.
module tb_softmax_result_uart_tx;

    localparam int DW  = 16;
    localparam int NC  = 4;
    localparam int CPB = 4;
    localparam int NB  = 3 + 2 * NC;
    localparam int FL  = NB * 10 * CPB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW*NC-1:0] in_vec = '0;
    logic           in_valid = 1'b0;
    logic           in_ready, tx, busy, frame_done, overrun;
    logic [2:0]     class_idx;
    logic [7:0]     led;

    int n_tests = 0;
    int n_fail  = 0;

    softmax_result_uart_tx #(
        .DATA_WIDTH(DW), .NUM_CLASSES(NC), .CLKS_PER_BIT(CPB), .HEADER(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .tx(tx), .busy(busy), .class_idx(class_idx), .led(led),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_argmax(input logic [DW*NC-1:0] v);
        int best = 0;
        for (int k = 1; k < NC; k++)
            if (v[k*DW +: DW] > v[best*DW +: DW]) best = k;
        return best;
    endfunction

    function automatic logic [DW*NC-1:0] rand_vec(input bit ties);
        logic [DW*NC-1:0] v;
        for (int k = 0; k < NC; k++)
            v[k*DW +: DW] = ties ? DW'($urandom_range(0, 3) << 12) : DW'($urandom);
        return v;
    endfunction

    // Waits for the start bit, captures the whole frame cycle by cycle and checks it.
    task automatic recv_frame(input logic [DW*NC-1:0] v, input string tag);
        logic [7:0]  exp_b [NB];
        logic [7:0]  got_b;
        logic [15:0] w;
        logic        s [FL+1];
        logic        fd_last, busy_mid;
        int idx, n, len_err, frm_err, fd_early, base;

        idx      = ref_argmax(v);
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'(idx);
        for (int k = 0; k < NC; k++) begin
            w = v[k*DW +: DW];
            exp_b[2+2*k] = w[15:8];
            exp_b[3+2*k] = w[7:0];
        end
        exp_b[NB-1] = 8'h00;
        for (int b = 1; b < NB - 1; b++) exp_b[NB-1] ^= exp_b[b];

        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            chk({tag, "_start_timeout"}, 32'(tx), 32'd0);
            return;
        end
        chk({tag, "_latency"}, 32'(n), 32'(NC + 3));

        s[0] = tx;
        fd_early = 0;
        busy_mid = 1'b0;
        fd_last  = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            @(negedge clk);
            s[i] = tx;
            if (i < FL && frame_done === 1'b1) fd_early++;
            if (i == FL / 2) busy_mid = busy;
            if (i == FL) fd_last = frame_done;
        end

        len_err = 0;
        frm_err = 0;
        for (int b = 0; b < NB; b++) begin
            got_b = '0;
            for (int k = 0; k < 10; k++) begin
                base = (b * 10 + k) * CPB;
                for (int j = 1; j < CPB; j++)
                    if (s[base+j] !== s[base]) len_err++;
                if (k == 0 && s[base + CPB/2] !== 1'b0) frm_err++;
                if (k == 9 && s[base + CPB/2] !== 1'b1) frm_err++;
                if (k >= 1 && k <= 8) got_b[k-1] = s[base + CPB/2];
            end
            chk($sformatf("%s_byte%0d", tag, b), 32'(got_b), 32'(exp_b[b]));
        end
        chk({tag, "_bit_len"}, 32'(len_err), 32'd0);
        chk({tag, "_framing"}, 32'(frm_err), 32'd0);
        chk({tag, "_busy_mid"}, 32'(busy_mid), 32'd1);
        chk({tag, "_fd_early"}, 32'(fd_early), 32'd0);
        chk({tag, "_fd_at_end"}, 32'(fd_last), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_class_idx"}, 32'(class_idx), 32'(idx));
        chk({tag, "_led"}, 32'(led), 32'(8'd1 << idx));
    endtask

    task automatic pulse_and_recv(input logic [DW*NC-1:0] v, input string tag);
        in_vec   = v;
        in_valid = 1'b1;
        fork
            begin @(negedge clk); in_valid = 1'b0; end
            recv_frame(v, tag);
        join
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [DW*NC-1:0] v1, v2;
        int starts;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pulse_and_recv({16'h0400, 16'h0800, 16'h2000, 16'h0100}, "basic");
        pulse_and_recv({4{16'h1000}}, "tie");
        for (int r = 0; r < 6; r++)
            pulse_and_recv(rand_vec(r[0]), $sformatf("rand%0d", r));

        // Level-held valid: one frame only.
        v1 = rand_vec(1'b0);
        in_vec   = v1;
        in_valid = 1'b1;
        recv_frame(v1, "held");
        starts = 0;
        repeat (1500) begin
            @(negedge clk);
            if (tx === 1'b0) starts++;
        end
        chk("held_extra_start", 32'(starts), 32'd0);
        chk("held_overrun", 32'(overrun), 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Second rising edge while the third byte is on the wire.
        v1 = rand_vec(1'b0);
        v2 = ~v1;
        in_vec   = v1;
        in_valid = 1'b1;
        fork
            recv_frame(v1, "ovr");
            begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (NC + 3 + 2 * 10 * CPB + 10) @(negedge clk);
                in_vec   = v2;
                in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
            end
        join
        chk("ovr_sticky", 32'(overrun), 32'd1);
        starts = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx === 1'b0) starts++;
        end
        chk("ovr_no_second_frame", 32'(starts), 32'd0);
        chk("ovr_idle_busy", 32'(busy), 32'd0);

        // Async reset mid data bit of the second byte.
        v1 = rand_vec(1'b0);
        in_vec   = v1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NC + 3 + 10 * CPB + 3 * CPB) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_class_idx", 32'(class_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse_and_recv(rand_vec(1'b0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
